cmd_tx_scheduler: RTL and testbench

CMD_TX_SCHEDULER -- requirements
Module: cmd_tx_scheduler

---
 rtl/cmd_tx_if.sv | 29 ++
 rtl/cmd_tx_scheduler.sv | 180 ++++++++++++++++++
 tb/tb_cmd_tx_scheduler.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cmd_tx_if.sv
// cmd_tx_if -- bundle between the command requesters and cmd_tx_scheduler.
//   req_key/key_data : keypad request pulse and its command byte
//   req_spd/spd_data : speed-entry request pulse and its command byte
//   data/senddata    : frame byte and transmit strobe toward the transmitter
//   ack_key/ack_spd  : one-cycle grant pulses back to the requesters
//   busy, ovr_cnt    : scheduler status
// master = requester/monitor side, slave = scheduler side.
interface cmd_tx_if;
    logic       req_key;
    logic [7:0] key_data;
    logic       req_spd;
    logic [7:0] spd_data;
    logic [7:0] data;
    logic       senddata;
    logic       ack_key;
    logic       ack_spd;
    logic       busy;
    logic [3:0] ovr_cnt;

    modport master (
        output req_key, key_data, req_spd, spd_data,
        input  data, senddata, ack_key, ack_spd, busy, ovr_cnt
    );

    modport slave (
        input  req_key, key_data, req_spd, spd_data,
        output data, senddata, ack_key, ack_spd, busy, ovr_cnt
    );
endinterface

// File: rtl/cmd_tx_scheduler.sv
// cmd_tx_scheduler -- arbitrates two one-entry command queues (keypad, speed)
// onto a single strobed transmit link.
//   clk_100k : system clock, rising edge
//   rst      : asynchronous active-high reset
//   bus      : cmd_tx_if.slave (requests in; data/senddata/acks/busy/ovr_cnt out)
// Each frame holds senddata high for HOLD cycles, followed by GAP low cycles.
// Round-robin between requesters; after a speed frame (data[7:6]==01) the last
// sent 001xxxxx byte is replayed (no ack) before anything else.
// Optional macro CMD_TX_SCHEDULER_KEEPALIVE_EN: resend the last byte after
// KEEPALIVE idle cycles with nothing pending.
module cmd_tx_scheduler #(
    parameter int HOLD      = 30,
    parameter int GAP       = 10,
    parameter int KEEPALIVE = 2000
) (
    input logic     clk_100k,
    input logic     rst,
    cmd_tx_if.slave bus
);
    localparam int CW = $clog2(((HOLD > GAP) ? HOLD : GAP) + 1);

    if (HOLD < 1 || GAP < 1 || KEEPALIVE < 1) begin : g_bad_param
        $error("cmd_tx_scheduler: HOLD, GAP and KEEPALIVE must be >= 1");
    end

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          key_vld, spd_vld;
    logic [7:0]    key_byte, spd_byte;
    logic          last_spd;    // last requester grant went to speed
    logic          rest_vld;    // a 001xxxxx byte has been sent
    logic [7:0]    rest_byte;
    logic          rest_pend;   // replay owed after a speed frame

`ifdef CMD_TX_SCHEDULER_KEEPALIVE_EN
    localparam int KW = $clog2(KEEPALIVE + 1);
    logic [KW-1:0] idle_cnt;
    logic          sent_any;
`endif

    logic       gnt_key, gnt_spd, gnt_rest, gnt_ka, launch;
    logic [7:0] launch_byte;

    always_comb begin
        gnt_key  = 1'b0;
        gnt_spd  = 1'b0;
        gnt_rest = 1'b0;
        gnt_ka   = 1'b0;
        if (state == S_IDLE) begin
            if (rest_pend)
                gnt_rest = 1'b1;
            else if (key_vld && spd_vld) begin
                gnt_key = last_spd;
                gnt_spd = !last_spd;
            end else if (key_vld)
                gnt_key = 1'b1;
            else if (spd_vld)
                gnt_spd = 1'b1;
`ifdef CMD_TX_SCHEDULER_KEEPALIVE_EN
            else if (sent_any && idle_cnt == KW'(KEEPALIVE - 1))
                gnt_ka = 1'b1;
`endif
        end
        launch = gnt_key | gnt_spd | gnt_rest | gnt_ka;
        // keepalive replays whatever is still on the data lines
        launch_byte = gnt_key  ? key_byte  :
                      gnt_spd  ? spd_byte  :
                      gnt_rest ? rest_byte : bus.data;
    end

    always_ff @(posedge clk_100k or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            cnt          <= '0;
            bus.data     <= '0;
            bus.senddata <= 1'b0;
            bus.ack_key  <= 1'b0;
            bus.ack_spd  <= 1'b0;
            bus.busy     <= 1'b0;
            last_spd     <= 1'b1;
            rest_vld     <= 1'b0;
            rest_byte    <= '0;
            rest_pend    <= 1'b0;
`ifdef CMD_TX_SCHEDULER_KEEPALIVE_EN
            idle_cnt     <= '0;
            sent_any     <= 1'b0;
`endif
        end else begin
            bus.ack_key <= gnt_key;
            bus.ack_spd <= gnt_spd;
            case (state)
                S_IDLE: begin
                    if (launch) begin
                        bus.data     <= launch_byte;
                        bus.senddata <= 1'b1;
                        bus.busy     <= 1'b1;
                        cnt          <= '0;
                        state        <= S_SEND;
                        if (gnt_key) last_spd <= 1'b0;
                        if (gnt_spd) last_spd <= 1'b1;
                        if (gnt_rest)
                            rest_pend <= 1'b0;
                        else if (launch_byte[7:6] == 2'b01)
                            rest_pend <= rest_vld;
                        if (launch_byte[7:5] == 3'b001) begin
                            rest_vld  <= 1'b1;
                            rest_byte <= launch_byte;
                        end
`ifdef CMD_TX_SCHEDULER_KEEPALIVE_EN
                        sent_any <= 1'b1;
                        idle_cnt <= '0;
                    end else if (idle_cnt != KW'(KEEPALIVE - 1)) begin
                        idle_cnt <= idle_cnt + 1'b1;
`endif
                    end
                end
                S_SEND: begin
                    if (cnt == CW'(HOLD - 1)) begin
                        bus.senddata <= 1'b0;
                        cnt          <= '0;
                        // the IDLE decision cycle is the last low cycle of the gap
                        if (GAP == 1) begin
                            state    <= S_IDLE;
                            bus.busy <= 1'b0;
                        end else begin
                            state <= S_GAP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_GAP: begin
                    if (cnt == CW'(GAP - 2)) begin
                        state    <= S_IDLE;
                        bus.busy <= 1'b0;
                        cnt      <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Pending entries: a grant clears the flag, a req on the same edge refills
    // it without counting as an overwrite.
    logic       ovr_key, ovr_spd;
    logic [4:0] ovr_sum;

    always_comb begin
        ovr_key = bus.req_key && key_vld && !gnt_key;
        ovr_spd = bus.req_spd && spd_vld && !gnt_spd;
        ovr_sum = {1'b0, bus.ovr_cnt} + {4'd0, ovr_key} + {4'd0, ovr_spd};
    end

    always_ff @(posedge clk_100k or posedge rst) begin
        if (rst) begin
            key_vld     <= 1'b0;
            key_byte    <= '0;
            spd_vld     <= 1'b0;
            spd_byte    <= '0;
            bus.ovr_cnt <= '0;
        end else begin
            if (gnt_key) key_vld <= 1'b0;
            if (gnt_spd) spd_vld <= 1'b0;
            if (bus.req_key) begin
                key_vld  <= 1'b1;
                key_byte <= bus.key_data;
            end
            if (bus.req_spd) begin
                spd_vld  <= 1'b1;
                spd_byte <= bus.spd_data;
            end
            bus.ovr_cnt <= (ovr_sum > 5'd15) ? 4'hF : ovr_sum[3:0];
        end
    end
endmodule

// File: tb/tb_cmd_tx_scheduler.sv
// tb_cmd_tx_scheduler -- randomized and directed stimulus for cmd_tx_scheduler,
// checked every cycle against a timestamp-based frame model, plus literal
// frame/timing expectations for the directed scenarios.
module tb_cmd_tx_scheduler;
    localparam int HOLD      = 30;
    localparam int GAP       = 10;
    localparam int KEEPALIVE = 2000;

    logic clk_100k = 1'b0;
    logic rst      = 1'b1;
    always #5 clk_100k = ~clk_100k;

    cmd_tx_if bus ();

    cmd_tx_scheduler #(.HOLD(HOLD), .GAP(GAP), .KEEPALIVE(KEEPALIVE)) dut (
        .clk_100k (clk_100k),
        .rst      (rst),
        .bus      (bus)
    );

    int nchk  = 0;
    int nfail = 0;
    int cyc   = 0;

    // ---------------- behavioural model (frame timestamps) ----------------
    int         m_start;
    bit         m_sent;
    bit         mk_v, ms_v, m_last_spd, m_rest_v, m_rest_pend, m_ack_k, m_ack_s;
    logic [7:0] mk_b, ms_b, m_rest_b, m_data;
    int         m_ovr;

    task automatic model_reset();
        m_start = 0; m_sent = 0; mk_v = 0; ms_v = 0; m_last_spd = 1;
        m_rest_v = 0; m_rest_pend = 0; m_ack_k = 0; m_ack_s = 0;
        mk_b = 0; ms_b = 0; m_rest_b = 0; m_data = 0; m_ovr = 0;
    endtask

    task automatic model_step(input int n, input bit rk, input logic [7:0] kd,
                              input bit rs, input logic [7:0] sd);
        bit gk, gs, gr, ga;
        logic [7:0] b;
        gk = 0; gs = 0; gr = 0; ga = 0;
        if (!m_sent || (n - m_start) >= HOLD + GAP) begin
            if (m_rest_pend) gr = 1;
            else if (mk_v && ms_v) begin
                if (m_last_spd) gk = 1; else gs = 1;
            end
            else if (mk_v) gk = 1;
            else if (ms_v) gs = 1;
`ifdef CMD_TX_SCHEDULER_KEEPALIVE_EN
            else if (m_sent && (n - m_start) == HOLD + GAP - 1 + KEEPALIVE) ga = 1;
`endif
        end
        if (gk || gs || gr || ga) begin
            b = gk ? mk_b : gs ? ms_b : gr ? m_rest_b : m_data;
            if (gr) m_rest_pend = 0;
            else if (b[7:6] == 2'b01 && m_rest_v) m_rest_pend = 1;
            if (b[7:5] == 3'b001) begin m_rest_v = 1; m_rest_b = b; end
            m_data = b; m_start = n; m_sent = 1;
            if (gk) begin mk_v = 0; m_last_spd = 0; end
            if (gs) begin ms_v = 0; m_last_spd = 1; end
        end
        m_ack_k = gk; m_ack_s = gs;
        if (rk) begin if (mk_v) m_ovr++; mk_v = 1; mk_b = kd; end
        if (rs) begin if (ms_v) m_ovr++; ms_v = 1; ms_b = sd; end
        if (m_ovr > 15) m_ovr = 15;
    endtask

    // ---------------- frame log taken from the DUT ----------------
    int rise_q[$], dat_q[$], ak_q[$], as_q[$], wid_q[$];
    int rise_last = 0, busy_fall = 0;
    bit prev_send = 0, prev_busy = 0;

    task automatic clear_log();
        rise_q.delete(); dat_q.delete(); ak_q.delete(); as_q.delete(); wid_q.delete();
    endtask

    // compare process: one combined check per cycle, sampled 1 time unit after the edge
    initial begin
        bit e_send, e_busy;
        model_reset();
        forever begin
            @(posedge clk_100k);
            #1;
            cyc++;
            if (rst) model_reset();
            else model_step(cyc, bus.req_key, bus.key_data, bus.req_spd, bus.spd_data);
            e_send = m_sent && (cyc - m_start) < HOLD;
            e_busy = m_sent && (cyc - m_start) < HOLD + GAP - 1;
            nchk++;
            if (bus.data !== m_data || bus.senddata !== e_send || bus.ack_key !== m_ack_k ||
                bus.ack_spd !== m_ack_s || bus.busy !== e_busy || bus.ovr_cnt !== 4'(m_ovr)) begin
                nfail++;
                $display("FAIL model_cmp cyc=%0d got data=%h send=%b ack=%b%b busy=%b ovr=%0d want data=%h send=%b ack=%b%b busy=%b ovr=%0d",
                         cyc, bus.data, bus.senddata, bus.ack_key, bus.ack_spd, bus.busy, bus.ovr_cnt,
                         m_data, e_send, m_ack_k, m_ack_s, e_busy, m_ovr);
            end
            if (bus.senddata && !prev_send) begin
                rise_q.push_back(cyc); dat_q.push_back(int'(bus.data));
                ak_q.push_back(int'(bus.ack_key)); as_q.push_back(int'(bus.ack_spd));
                rise_last = cyc;
            end
            if (!bus.senddata && prev_send) wid_q.push_back(cyc - rise_last);
            if (!bus.busy && prev_busy) busy_fall = cyc;
            prev_send = bus.senddata;
            prev_busy = bus.busy;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) begin @(posedge clk_100k); #2; end
    endtask

    task automatic check(input string name, input int act, input int exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic chk_frame(input string name, input int i, input int c, input int d,
                             input int ak, input int as_);
        if (rise_q.size() <= i) check({name, " present"}, rise_q.size(), i + 1);
        else begin
            check({name, " cycle"}, rise_q[i], c);
            check({name, " data"}, dat_q[i], d);
            check({name, " ack_key"}, ak_q[i], ak);
            check({name, " ack_spd"}, as_q[i], as_);
        end
    endtask

    // one-cycle request pulse(s); e = edge number at which they are sampled
    task automatic pulse(input bit k, input bit s, input logic [7:0] kd,
                         input logic [7:0] sd, output int e);
        bus.req_key = k; bus.key_data = kd;
        bus.req_spd = s; bus.spd_data = sd;
        e = cyc + 1;
        step(1);
        bus.req_key = 0; bus.req_spd = 0;
    endtask

    task automatic do_reset();
        rst = 1; step(2); rst = 0;
    endtask

    function automatic logic [7:0] rnd_byte();
        logic [7:0] b;
        b = 8'($urandom);
        case ($urandom_range(0, 3))
            0: b[7:5] = 3'b001;
            1: b[7:6] = 2'b01;
            default: ;
        endcase
        return b;
    endfunction

    // ---------------- directed + random sequence ----------------
    initial begin
        int e, e2;
        bus.req_key = 0; bus.key_data = 0; bus.req_spd = 0; bus.spd_data = 0;
        #2;
        step(3);
        check("reset data", int'(bus.data), 0);
        check("reset senddata", int'(bus.senddata), 0);
        check("reset busy", int'(bus.busy), 0);
        check("reset ovr_cnt", int'(bus.ovr_cnt), 0);
        rst = 0;

        // single keypad request
        step(2); clear_log();
        pulse(1, 0, 8'h24, 8'h00, e);
        step(50);
        check("single frame count", rise_q.size(), 1);
        chk_frame("single", 0, e + 1, 'h24, 1, 0);
        if (wid_q.size() > 0) check("single width", wid_q[0], HOLD);
        else check("single width present", 0, 1);
        check("single busy fall", busy_fall, e + 40);

        // simultaneous pair from reset, then second pair while the first sends
        do_reset(); clear_log();
        pulse(1, 1, 8'h21, 8'h50, e);
        step(10);
        pulse(1, 1, 8'h22, 8'h51, e2);
        step(170);
        check("pair frame count", rise_q.size(), 4);
        chk_frame("pair key1", 0, e + 1, 'h21, 1, 0);
        chk_frame("pair spd", 1, e + 41, 'h51, 0, 1);
        chk_frame("pair restore", 2, e + 81, 'h21, 0, 0);
        chk_frame("pair key2", 3, e + 121, 'h22, 1, 0);

        // restore after speed frame
        do_reset(); clear_log();
        pulse(1, 0, 8'h28, 8'h00, e);
        step(5);
        pulse(0, 1, 8'h00, 8'h4A, e2);
        step(130);
        check("restore frame count", rise_q.size(), 3);
        chk_frame("restore f0", 0, e + 1, 'h28, 1, 0);
        chk_frame("restore f1", 1, e + 41, 'h4A, 0, 1);
        chk_frame("restore f2", 2, e + 81, 'h28, 0, 0);
        if (wid_q.size() > 0 && rise_q.size() > 1)
            check("restore gap", rise_q[1] - rise_q[0] - wid_q[0], GAP);
        else check("restore gap present", 0, 1);

        // overwrites and saturation
        do_reset(); clear_log();
        pulse(1, 0, 8'h10, 8'h00, e);
        step(3);
        pulse(0, 1, 8'h00, 8'h41, e2);
        pulse(0, 1, 8'h00, 8'h42, e2);
        pulse(0, 1, 8'h00, 8'h43, e2);
        step(1);
        check("ovr after 3 pulses", int'(bus.ovr_cnt), 2);
        step(40);
        for (int i = 0; i < 18; i++) pulse(0, 1, 8'h00, 8'(8'h60 + i), e2);
        step(1);
        check("ovr saturated", int'(bus.ovr_cnt), 15);
        step(60);
        chk_frame("ovr first", 0, e + 1, 'h10, 1, 0);
        chk_frame("ovr newest", 1, e + 41, 'h43, 0, 1);
        chk_frame("ovr last", 2, e + 81, 'h71, 0, 1);

        // reset in the middle of a speed frame with a restore and a key pending
        do_reset(); clear_log();
        pulse(1, 0, 8'h2A, 8'h00, e);
        step(5);
        pulse(0, 1, 8'h00, 8'h44, e2);
        while (cyc < e + 45) step(1);
        pulse(1, 0, 8'h11, 8'h00, e2);
        while (cyc < e + 52) step(1);
        check("abort pre senddata", int'(bus.senddata), 1);
        check("abort pre data", int'(bus.data), 'h44);
        rst = 1;
        #1;
        check("abort senddata", int'(bus.senddata), 0);
        check("abort data", int'(bus.data), 0);
        check("abort busy", int'(bus.busy), 0);
        check("abort acks", int'({bus.ack_key, bus.ack_spd}), 0);
        check("abort ovr", int'(bus.ovr_cnt), 0);
        #1;
        step(2); rst = 0;
        clear_log();
        step(150);
        check("abort silent", rise_q.size(), 0);
        rst = 1; step(2); rst = 0;
        clear_log();
        pulse(1, 0, 8'h12, 8'h00, e);
        step(5);
        chk_frame("post release", 0, e + 1, 'h12, 1, 0);

        // random traffic against the model, with one reset in the middle
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            if (i == 1000) begin
                bus.req_key = 0; bus.req_spd = 0;
                do_reset();
            end
            bus.req_key  = ($urandom_range(0, 29) == 0);
            bus.key_data = rnd_byte();
            bus.req_spd  = ($urandom_range(0, 29) == 0);
            bus.spd_data = rnd_byte();
            step(1);
        end
        bus.req_key = 0; bus.req_spd = 0;
        step(60);

        // idle link behaviour
        do_reset(); clear_log();
        pulse(1, 0, 8'h25, 8'h00, e);
`ifdef CMD_TX_SCHEDULER_KEEPALIVE_EN
        step(KEEPALIVE + 60);
        check("keepalive frame count", rise_q.size(), 2);
        chk_frame("keepalive", 1, e + 40 + KEEPALIVE, 'h25, 0, 0);
`else
        step(KEEPALIVE + 100);
        check("silent idle frame count", rise_q.size(), 1);
        chk_frame("silent idle", 0, e + 1, 'h25, 1, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
